consumer_request_queue: RTL and testbench
=========================================

CONSUMER_REQUEST_QUEUE -- requirements
Module: consumer_request_queue

Interface
REQ-001: ADDR_WIDTH, default 4, request address width in bits.
REQ-002: VALUE_WIDTH, default 8, request data width in bits.
REQ-003: DEPTH, default 4, number of queue entries; SHALL be a power of two and at least 2.
REQ-004: REQ_WIDTH, localparam equal to ADDR_WIDTH+VALUE_WIDTH+2, width of a scheduler request word.
REQ-005: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006: reset  input  1  asynchronous, active-low reset.
REQ-007: in_valid  input  1  the consumer offers a request this cycle.
REQ-008: in_ready  output  1  the queue accepts the offered request this cycle.
REQ-009: in_we  input  1  1 = write request, 0 = read request.
REQ-010: in_addr  input  ADDR_WIDTH  request address.
REQ-011: in_value  input  VALUE_WIDTH  write data; ignored by the scheduler for reads.
REQ-012: out_req  output  REQ_WIDTH  head request to rr_scheduling_kernel; packed as {valid, we, addr, value}, with valid at the MSB.
REQ-013: grant  input  1  the scheduler consumed the head request this cycle.
REQ-014: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015: full, empty  output  1 each  occupancy flags.

Function
REQ-016: A push SHALL occur on a rising edge where in_valid && in_ready; the entry stored is {in_we, in_addr, in_value}.
REQ-017: in_ready SHALL equal !full, combinationally; there is no push while full, even if a pop occurs in the same cycle.
REQ-018: out_req valid bit SHALL equal !empty; the remaining out_req bits SHALL present the oldest entry when non-empty and SHALL be all zero when empty.
REQ-019: A pop SHALL occur on a rising edge where grant && !empty; grant while empty SHALL be ignored with no state change.
REQ-020: On a simultaneous push and pop, both SHALL take effect; count SHALL be unchanged and order SHALL be preserved.
REQ-021: Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; count SHALL be tracked separately.
REQ-022: full SHALL be (count == DEPTH) and empty SHALL be (count == 0); both are registered-state derived.
REQ-023: Latency, no bypass: a request pushed at edge N SHALL appear on out_req after edge N if the queue was empty.
REQ-024: Requests SHALL leave the queue in strict FIFO order; no reordering, merging or dropping.

Reset
REQ-025: Asserting reset low SHALL immediately clear the pointers and count to 0, making out_req all zero, empty 1, full 0 and in_ready 1.
REQ-026: Reset asserted mid-operation SHALL discard all queued entries; entry storage need not be cleared.
REQ-027: Reset deassertion SHALL be synchronised externally; the block SHALL accept a push on the first edge after release.

Configuration
REQ-028: The macro REQ_QUEUE_BYPASS_EN SHALL control the empty-queue bypass path.
REQ-029: With REQ_QUEUE_BYPASS_EN defined, when empty && in_valid, out_req SHALL combinationally present {1, in_we, in_addr, in_value}.
REQ-030: In that bypass case, if grant is also high in the same cycle, the request SHALL be consumed without being stored and count SHALL stay 0; otherwise it is pushed normally.
REQ-031: Without REQ_QUEUE_BYPASS_EN, REQ-023 latency applies and out_req SHALL depend only on registered state.

Structure
REQ-032: The shared package saladin_pkg SHALL hold a function computing REQ_WIDTH from ADDR_WIDTH and VALUE_WIDTH.
REQ-033: saladin_pkg SHALL also hold the out_req field-offset constants (VALID, WE, ADDR and VALUE positions), which rr_scheduling_kernel also uses.
REQ-034: Storage SHALL be an inline register array; no sub-module is required.

Verification
REQ-035: Reset, then idle for 3 cycles -> out_req = 0, empty = 1, count = 0, in_ready = 1.
REQ-036: Push 4 writes with addr 1..4 and value 0x11..0x44 -> full = 1, in_ready = 0; a 5th offer is not accepted; grants then pop addr 1,2,3,4 in order.
REQ-037: With count = 2, assert push and grant together for 5 cycles -> count stays 2, order is preserved, and pointer wrap is exercised.
REQ-038: Assert grant while empty -> no change and count stays 0; next push of read addr 0xA -> out_req = {1,0,0xA,0x00} one edge later.
REQ-039: Assert reset low mid-stream with count = 3 -> out_req = 0 and count = 0 immediately, before the next clock edge.
REQ-040: Build with REQ_QUEUE_BYPASS_EN, empty queue, in_valid and grant high with addr 0x5 -> out_req valid in the same cycle and count = 0 after the edge.

Source files
------------

// File: rtl/saladin_pkg.sv
// Shared scheduler request layout: width helper and out_req field offsets.
// Used by consumer_request_queue and rr_scheduling_kernel.
package saladin_pkg;

  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_VALUE_WIDTH = 8;

  localparam int VALUE_POS = 0;

  function automatic int req_width(
    input int aw,
    input int vw
  );
    return aw + vw + 2;
  endfunction

  function automatic int addr_pos(
    input int vw
  );
    return vw;
  endfunction

  function automatic int we_pos(
    input int aw,
    input int vw
  );
    return aw + vw;
  endfunction

  function automatic int valid_pos(
    input int aw,
    input int vw
  );
    return aw + vw + 1;
  endfunction

  localparam int ADDR_POS  = DEF_VALUE_WIDTH;
  localparam int WE_POS    = DEF_ADDR_WIDTH + DEF_VALUE_WIDTH;
  localparam int VALID_POS = DEF_ADDR_WIDTH + DEF_VALUE_WIDTH + 1;

endpackage

// File: rtl/consumer_request_queue.sv
// Request FIFO between a consumer and rr_scheduling_kernel.
// Optional empty-queue bypass: define REQ_QUEUE_BYPASS_EN.
module consumer_request_queue
  import saladin_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 4,
  parameter  int VALUE_WIDTH = 8,
  parameter  int DEPTH       = 4,
  localparam int REQ_WIDTH   = req_width(ADDR_WIDTH, VALUE_WIDTH),
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [VALUE_WIDTH-1:0] in_value,
  output logic [REQ_WIDTH-1:0]   out_req,
  input  logic                   grant,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + VALUE_WIDTH + 1;
  localparam int VP = valid_pos(ADDR_WIDTH, VALUE_WIDTH);
  localparam int WP = we_pos(ADDR_WIDTH, VALUE_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic [EW-1:0] head;
  logic [EW-1:0] in_entry;
  logic          push;
  logic          pop;
  logic          bypass_show;
  logic          bypass_take;

  assign in_entry = {in_we, in_addr, in_value};
  assign head     = mem[rd_ptr];

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;

`ifdef REQ_QUEUE_BYPASS_EN
  assign bypass_show = empty && in_valid;
  assign bypass_take = bypass_show && grant;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed request is consumed straight from the input.
  assign push = in_valid && in_ready && !bypass_take;
  assign pop  = grant && !empty;

  always_comb begin
    out_req = '0;
    unique case (1'b1)
      !empty: begin
        out_req[VP]            = 1'b1;
        out_req[WP:VALUE_POS]  = head;
      end
      bypass_show: begin
        out_req[VP]            = 1'b1;
        out_req[WP:VALUE_POS]  = in_entry;
      end
      default: out_req = '0;
    endcase
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push && !pop: cnt <= cnt + CW'(1);
        pop && !push: cnt <= cnt - CW'(1);
        default:      cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_consumer_request_queue.sv
// Scoreboard bench for consumer_request_queue with a queue-based model.
// Honours REQ_QUEUE_BYPASS_EN when the design is built with it.
module tb_consumer_request_queue;

  localparam int AW = 4;
  localparam int VW = 8;
  localparam int D  = 4;
  localparam int RW = AW + VW + 2;
  localparam int EW = AW + VW + 1;
  localparam int CW = 3;

`ifdef REQ_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_we = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [VW-1:0] in_value = '0;
  logic          grant = 1'b0;
  logic          in_ready;
  logic [RW-1:0] out_req;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb[$];
  int mcount = 0;

  consumer_request_queue #(
    .ADDR_WIDTH (AW),
    .VALUE_WIDTH(VW),
    .DEPTH      (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_we   (in_we),
    .in_addr (in_addr),
    .in_value(in_value),
    .out_req (out_req),
    .grant   (grant),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [VW-1:0] val, input bit g);
    bit push;
    bit pop;
    int nxt;
    @(negedge clk);
    in_valid = v;
    in_we    = we;
    in_addr  = a;
    in_value = val;
    grant    = g;
    #1;
    check("count", 64'(count), 64'(mcount));
    check("empty", 64'(empty), 64'(mcount == 0));
    check("full", 64'(full), 64'(mcount == D));
    check("in_ready", 64'(in_ready), 64'(mcount < D));
    push = v && (mcount < D);
    pop  = g && ((mcount > 0) || (BYP && v));
    if (push) sb.push_back({we, a, val});
    nxt = mcount + int'(push) - int'(pop);
    @(posedge clk);
    mcount = nxt;
  endtask

  task automatic idle(input bit g);
    cycle(1'b0, 1'b0, '0, '0, g);
  endtask

  // Monitor: compares the presented head against the scoreboard front.
  always @(negedge clk) begin
    bit exp_v;
    #2;
    if (reset) begin
      exp_v = (mcount > 0) || (BYP && in_valid);
      if (exp_v) begin
        if (sb.size() == 0) begin
          check("sb_has_entry", 64'(0), 64'(1));
        end else begin
          check("out_req", 64'(out_req), 64'({1'b1, sb[0]}));
          if (grant) void'(sb.pop_front());
        end
      end else begin
        check("out_req_idle", 64'(out_req), 64'(0));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) idle(1'b0);

    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 1'b1, AW'(i), VW'(i * 17), 1'b0);
    cycle(1'b1, 1'b1, 4'h5, 8'h55, 1'b0);
    check("full_after_4", 64'(full), 64'(1));
    repeat (4) idle(1'b1);
    idle(1'b0);

    cycle(1'b1, 1'b0, 4'h3, 8'h01, 1'b0);
    cycle(1'b1, 1'b1, 4'h7, 8'h02, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'($urandom), AW'($urandom), VW'($urandom), 1'b1);
    check("count_kept", 64'(count), 64'(2));
    repeat (2) idle(1'b1);

    idle(1'b1);
    check("grant_empty", 64'(count), 64'(0));
    cycle(1'b1, 1'b0, 4'hA, 8'h00, 1'b0);
    #1;
    check("latency_req", 64'(out_req), 64'(14'h2A00));
    idle(1'b1);

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, AW'(i + 8), VW'($urandom), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    grant = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("rst_out_req", 64'(out_req), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_ready", 64'(in_ready), 64'(1));
    sb.delete();
    mcount = 0;
    @(negedge clk);
    reset = 1'b1;

    cycle(1'b1, 1'b0, 4'h5, 8'h3C, 1'b1);
    #1;
    check("bypass_count", 64'(count), 64'(BYP ? 0 : 1));
    idle(1'b1);

    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom),
            VW'($urandom), ($urandom_range(0, 2) == 0));
    repeat (D + 1) idle(1'b1);
    check("drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
